// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: syncs, data-enable, pixel coordinates,
// linear ROM address, frame counter and pipeline-delayed sync copies.
module vga_timing_gen #(
    parameter int H_DISP   = 400,
    parameter int V_DISP   = 306,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_FRONT  = 10,
    parameter int PIPE_DLY = 3,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              VGA_hsync,
    output logic              VGA_vsync,
    output logic              VGA_de,
    output logic [10:0]       pixel_x,
    output logic [10:0]       pixel_y,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              frame_start,
    output logic [7:0]        frame_cnt,
    output logic              VGA_hsync_d,
    output logic              VGA_vsync_d,
    output logic              VGA_de_d
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_SYN  = 16'(H_SYNC);
    localparam logic [15:0] V_SYN  = 16'(V_SYNC);
    localparam logic [15:0] H_ACT0 = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] H_ACT1 = 16'(H_SYNC + H_BACK + H_DISP);
    localparam logic [15:0] V_ACT0 = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] V_ACT1 = 16'(V_SYNC + V_BACK + V_DISP);

    logic [15:0]       h_cnt_q, h_cnt_d;
    logic [15:0]       v_cnt_q, v_cnt_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic [10:0]       px_q, px_d;
    logic [10:0]       py_q, py_d;
    logic [ADDR_W-1:0] rom_q, rom_d;
    logic [ADDR_W-1:0] nxt_q, nxt_d;
    logic              fs_q, fs_d;
    logic              wrap_q, wrap_d;
    logic [7:0]        fc_q, fc_d;

    logic              origin;
    logic              h_last;
    logic              v_last;
    logic              h_act;
    logic              v_act;
    logic [ADDR_W-1:0] base;

    always_comb begin
        origin = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
        h_last = (h_cnt_q == H_LAST);
        v_last = (v_cnt_q == V_LAST);
        h_act  = (h_cnt_q >= H_ACT0) && (h_cnt_q < H_ACT1);
        v_act  = (v_cnt_q >= V_ACT0) && (v_cnt_q < V_ACT1);

        h_cnt_d = h_last ? 16'd0 : h_cnt_q + 16'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? 16'd0 : v_cnt_q + 16'd1;
        end

        hs_d = !(h_cnt_q < H_SYN);
        vs_d = !(v_cnt_q < V_SYN);
        de_d = h_act && v_act;
        px_d = de_d ? 11'(h_cnt_q - H_ACT0) : 11'd0;
        py_d = de_d ? 11'(v_cnt_q - V_ACT0) : 11'd0;

        // nxt_q holds the index of the next active pixel in this frame
        base  = origin ? '0 : nxt_q;
        rom_d = de_d ? base : (origin ? '0 : rom_q);
        nxt_d = de_d ? base + ADDR_W'(1) : base;

        fs_d   = origin;
        wrap_d = h_last && v_last;
        fc_d   = (origin && wrap_q) ? fc_q + 8'd1 : fc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= 16'd0;
            v_cnt_q <= 16'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            px_q    <= 11'd0;
            py_q    <= 11'd0;
            rom_q   <= '0;
            nxt_q   <= '0;
            fs_q    <= 1'b0;
            wrap_q  <= 1'b0;
            fc_q    <= 8'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            px_q    <= px_d;
            py_q    <= py_d;
            rom_q   <= rom_d;
            nxt_q   <= nxt_d;
            fs_q    <= fs_d;
            wrap_q  <= wrap_d;
            fc_q    <= fc_d;
        end
    end

    assign VGA_hsync   = hs_q;
    assign VGA_vsync   = vs_q;
    assign VGA_de      = de_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign rom_addr    = rom_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign VGA_hsync_d = hs_q;
            assign VGA_vsync_d = vs_q;
            assign VGA_de_d    = de_q;
        end else begin : g_dly
            // each stage packs {hsync, vsync, de}
            logic [2:0] dly_q [PIPE_DLY];
            logic [2:0] dly_d [PIPE_DLY];

            always_comb begin
                dly_d[0] = {hs_q, vs_q, de_q};
                for (int i = 1; i < PIPE_DLY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    if (!rst_n) begin
                        dly_q[i] <= 3'b110;
                    end else begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign VGA_hsync_d = dly_q[PIPE_DLY-1][2];
            assign VGA_vsync_d = dly_q[PIPE_DLY-1][1];
            assign VGA_de_d    = dly_q[PIPE_DLY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, raster-index reference model,
// random reset points, 257+ frames for frame counter wrap.
module tb_vga_timing_gen;

    localparam int HD = 8;
    localparam int VD = 5;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HF = 2;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VF = 1;
    localparam int DLY = 3;
    localparam int AW = 8;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          hs, vs, de, fs, hs_d, vs_d, de_d;
    logic [10:0]   px, py;
    logic [AW-1:0] ra;
    logic [7:0]    fc;

    logic          hs0, vs0, de0, fs0, hs0_d, vs0_d, de0_d;
    logic [10:0]   px0, py0;
    logic [AW-1:0] ra0;
    logic [7:0]    fc0;

    int total = 0;
    int bad = 0;
    int n = -2;
    int de_in_frame = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISP(HD), .V_DISP(VD), .H_SYNC(HS), .H_BACK(HB),
        .H_FRONT(HF), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF),
        .PIPE_DLY(DLY), .ADDR_W(AW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .VGA_hsync(hs), .VGA_vsync(vs), .VGA_de(de),
        .pixel_x(px), .pixel_y(py), .rom_addr(ra),
        .frame_start(fs), .frame_cnt(fc),
        .VGA_hsync_d(hs_d), .VGA_vsync_d(vs_d), .VGA_de_d(de_d)
    );

    vga_timing_gen #(
        .H_DISP(HD), .V_DISP(VD), .H_SYNC(HS), .H_BACK(HB),
        .H_FRONT(HF), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF),
        .PIPE_DLY(0), .ADDR_W(AW)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .VGA_hsync(hs0), .VGA_vsync(vs0), .VGA_de(de0),
        .pixel_x(px0), .pixel_y(py0), .rom_addr(ra0),
        .frame_start(fs0), .frame_cnt(fc0),
        .VGA_hsync_d(hs0_d), .VGA_vsync_d(vs0_d), .VGA_de_d(de0_d)
    );

    // raster index of what the outputs show; -1 means reset values
    always @(posedge clk) begin
        n <= rst_n ? n + 1 : -1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%0d want=%0d", nm, n, act, exp);
        end
    endtask

    function automatic void model(input int k, output logic e_hs,
                                  output logic e_vs, output logic e_de,
                                  output int e_px, output int e_py,
                                  output int e_ra, output logic e_fs,
                                  output int e_fc);
        int h, v;
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
        e_px = 0; e_py = 0; e_ra = 0; e_fs = 1'b0; e_fc = 0;
        if (k >= 0) begin
            h = k % HT;
            v = (k / HT) % VT;
            e_hs = (h >= HS);
            e_vs = (v >= VS);
            e_de = (h >= HS + HB) && (h < HS + HB + HD) &&
                   (v >= VS + VB) && (v < VS + VB + VD);
            if (e_de) begin
                e_px = h - (HS + HB);
                e_py = v - (VS + VB);
                e_ra = e_py * HD + e_px;
            end
            e_fs = (k % FR) == 0;
            e_fc = (k / FR) % 256;
        end
    endfunction

    always @(negedge clk) begin
        logic e_hs, e_vs, e_de, e_fs, d_hs, d_vs, d_de, x_fs;
        int e_px, e_py, e_ra, e_fc, x_px, x_py, x_ra, x_fc;
        if (n != -2) begin
            model(n, e_hs, e_vs, e_de, e_px, e_py, e_ra, e_fs, e_fc);
            model((n < 0) ? -1 : n - DLY, d_hs, d_vs, d_de,
                  x_px, x_py, x_ra, x_fs, x_fc);
            chk("hsync", hs, e_hs);
            chk("vsync", vs, e_vs);
            chk("de", de, e_de);
            chk("pixel_x", px, e_px);
            chk("pixel_y", py, e_py);
            chk("frame_start", fs, e_fs);
            chk("frame_cnt", fc, e_fc);
            if (e_de || e_fs || n < 0) chk("rom_addr", ra, e_ra);
            chk("hsync_d", hs_d, d_hs);
            chk("vsync_d", vs_d, d_vs);
            chk("de_d", de_d, d_de);
            chk("dly0_hsync_d", hs0_d, e_hs);
            chk("dly0_vsync_d", vs0_d, e_vs);
            chk("dly0_de_d", de0_d, e_de);
            if (e_de || e_fs || n < 0) chk("dly0_rom_addr", ra0, e_ra);
            chk("dly0_frame_cnt", fc0, e_fc);

            // hand-computed anchors for this 15x9 raster
            if (n == 50) begin
                chk("first_de", de, 1);
                chk("first_rom", ra, 0);
            end
            if (n == 117) begin
                chk("last_de_px", px, 7);
                chk("last_de_py", py, 4);
                chk("last_rom", ra, 39);
            end
            if (n == 2) chk("hsync_last_low", hs, 0);
            if (n == 3) chk("hsync_rise", hs, 1);
            if (n == 256 * FR) chk("fcnt_256", fc, 0);
            if (n == 257 * FR) chk("fcnt_257", fc, 1);

            if (n >= 0 && n % FR == 0) begin
                if (n > 0) chk("de_per_frame", de_in_frame, HD * VD);
                de_in_frame = de ? 1 : 0;
            end else if (n >= 0 && de) begin
                de_in_frame++;
            end else if (n < 0) begin
                de_in_frame = 0;
            end
        end
    end

    task automatic run(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    initial begin
        int r1, l1;
        r1 = $urandom_range(200, 700);
        l1 = $urandom_range(1, 3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run(r1);
        rst_n = 1'b0;
        run(l1);
        rst_n = 1'b1;
        run(257 * FR + 60);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run($urandom_range(150, 400));
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
